// File: rtl/fetch.sv
// Instruction-fetch stage: holds the fetch PC, issues one BRAM read per instruction,
// hands instr/pc to decode with a one-cycle pulse, then waits for the retire pulse.
module fetch #(
    parameter logic [18:0] RESET_PC = 19'd0,
    parameter int          IMEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        halt,
    input  logic        next_en,
    input  logic        jump,
    input  logic [18:0] jump_addr,
    output logic        imem_en,
    output logic [18:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        decode_en,
    output logic [31:0] instr,
    output logic [18:0] pc,
    output logic        busy,
    output logic [31:0] instr_count,
    output logic        proto_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EXEC} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(IMEM_LAT - 1);

    state_t      r_state;
    logic [18:0] r_fetch_pc;
    logic [1:0]  r_lat_cnt;
    logic [18:0] w_next_pc;

    // 19-bit add wraps 7FFFF to 0 on its own.
    assign w_next_pc = jump ? jump_addr : r_fetch_pc + 19'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_lat_cnt   <= 2'd0;
            imem_en     <= 1'b0;
            imem_addr   <= RESET_PC;
            decode_en   <= 1'b0;
            instr       <= 32'd0;
            pc          <= RESET_PC;
            busy        <= 1'b0;
            instr_count <= 32'd0;
            proto_err   <= 1'b0;
        end else begin
            imem_en   <= 1'b0;
            decode_en <= 1'b0;
            if (next_en && (r_state != S_EXEC))
                proto_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_fetch_pc <= RESET_PC;
                        imem_addr  <= RESET_PC;
                        imem_en    <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_lat_cnt <= LAT_LOAD;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid in the last WAIT cycle, IMEM_LAT cycles after ISSUE.
                    if (r_lat_cnt == 2'd0) begin
                        instr       <= imem_rdata;
                        pc          <= r_fetch_pc;
                        decode_en   <= 1'b1;
                        instr_count <= instr_count + 32'd1;
                        r_state     <= S_EXEC;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                end
                S_EXEC: begin
                    if (next_en) begin
                        r_fetch_pc <= w_next_pc;
                        if (halt) begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            imem_en   <= 1'b1;
                            imem_addr <= w_next_pc;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
